// File: rtl/fir_output_conditioner.sv
// Rescales the full-precision FIR output (round, then saturate to the sample width),
// optionally decimates, and buffers results in a FIFO behind a valid/ready handshake.
// Define FIR_SAT_COUNT_EN to add the saturating sat_count95 output.
module fir_output_conditioner #(
  parameter int IN_W       = 40,
  parameter int OUT_W      = 17,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock95,
  input  logic                          reset95,
  input  logic signed [IN_W-1:0]        filter_output95,
  input  logic                          in_valid95,
  output logic signed [OUT_W-1:0]       out_data95,
  output logic                          out_valid95,
  input  logic                          out_ready95,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level95,
  output logic                          sat_flag95,
`ifdef FIR_SAT_COUNT_EN
  output logic [15:0]                   sat_count95,
`endif
  output logic                          overflow95
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = 4;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [IN_W:0] HALF  = {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_CLAMP = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_CLAMP = {1'b1, {(OUT_W-1){1'b0}}};

  // One guard bit keeps the rounding add from wrapping at the most positive input.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    ext = $signed({x[IN_W-1], x}) + HALF;
    return ext >>> SHIFT;
  endfunction

  // Returns {saturated, sample}.
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] r);
    if (r > MAX_V)      return {1'b1, POS_CLAMP};
    else if (r < MIN_V) return {1'b1, NEG_CLAMP};
    else                return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic signed [IN_W:0]  rnd_p0_q, rnd_p0_d;
  logic                  vld_p0_q, vld_p0_d;
  logic [OUT_W-1:0]      smp_p1_q, smp_p1_d;
  logic                  sat_p1_q, sat_p1_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [CNT_W-1:0]      dec_cnt_q, dec_cnt_d;
  logic [OUT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  sat_flag_q, sat_flag_d;
  logic                  ovf_q, ovf_d;
  logic                  keep, push_req, pop, full, push, drop;
`ifdef FIR_SAT_COUNT_EN
  logic [15:0]           sat_cnt_q, sat_cnt_d;
`endif

  always_comb begin
    // Stage p0: round and shift
    vld_p0_d = in_valid95;
    rnd_p0_d = round_shift(filter_output95);
    // Stage p1: saturate to sample width
    vld_p1_d = vld_p0_q;
    {sat_p1_d, smp_p1_d} = saturate(rnd_p0_q);
    // Decimation and FIFO push/pop
    keep     = (dec_cnt_q == '0);
    push_req = vld_p1_q & keep;
    pop      = (level_q != '0) & out_ready95;
    full     = (level_q == FULL_LVL);
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    dec_cnt_d = dec_cnt_q;
    if (vld_p1_q) dec_cnt_d = (dec_cnt_q == CNT_LAST) ? '0 : dec_cnt_q + CNT_W'(1);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = smp_p1_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    sat_flag_d = push ? sat_p1_q : sat_flag_q;
    ovf_d      = ovf_q | drop;
`ifdef FIR_SAT_COUNT_EN
    sat_cnt_d = sat_cnt_q;
    if (push && sat_p1_q && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clock95) begin
    if (reset95) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      dec_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef FIR_SAT_COUNT_EN
      sat_cnt_q  <= '0;
`endif
    end else begin
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      dec_cnt_q  <= dec_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_flag_q <= sat_flag_d;
      ovf_q      <= ovf_d;
`ifdef FIR_SAT_COUNT_EN
      sat_cnt_q  <= sat_cnt_d;
`endif
    end
  end

  always_ff @(posedge clock95) begin
    rnd_p0_q <= rnd_p0_d;
    smp_p1_q <= smp_p1_d;
    sat_p1_q <= sat_p1_d;
    mem_q    <= mem_d;
  end

  // Head is forced to zero when empty so storage needs no reset.
  assign out_data95   = (level_q != '0) ? $signed(mem_q[rd_ptr_q]) : '0;
  assign out_valid95  = (level_q != '0);
  assign fifo_level95 = level_q;
  assign sat_flag95   = sat_flag_q;
  assign overflow95   = ovf_q;
`ifdef FIR_SAT_COUNT_EN
  assign sat_count95  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Directed bench: one instance keeps every sample, a second decimates by two.
module tb_fir_output_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic signed [39:0] din_a = '0, din_b = '0;
  logic               vld_a = 1'b0, vld_b = 1'b0;
  logic               rdy_a = 1'b0, rdy_b = 1'b0;
  logic signed [16:0] dout_a, dout_b;
  logic               ov_a, ov_b, sat_a, sat_b, ovf_a, ovf_b;
  logic [2:0]         lvl_a, lvl_b;
`ifdef FIR_SAT_COUNT_EN
  logic [15:0]        cnt_a, cnt_b;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fir_output_conditioner #(.DECIM(1), .FIFO_DEPTH(4)) dut_a (
    .clock95(clk), .reset95(rst), .filter_output95(din_a), .in_valid95(vld_a),
    .out_data95(dout_a), .out_valid95(ov_a), .out_ready95(rdy_a),
    .fifo_level95(lvl_a), .sat_flag95(sat_a),
`ifdef FIR_SAT_COUNT_EN
    .sat_count95(cnt_a),
`endif
    .overflow95(ovf_a));

  fir_output_conditioner #(.DECIM(2), .FIFO_DEPTH(4)) dut_b (
    .clock95(clk), .reset95(rst), .filter_output95(din_b), .in_valid95(vld_b),
    .out_data95(dout_b), .out_valid95(ov_b), .out_ready95(rdy_b),
    .fifo_level95(lvl_b), .sat_flag95(sat_b),
`ifdef FIR_SAT_COUNT_EN
    .sat_count95(cnt_b),
`endif
    .overflow95(ovf_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed_a(input logic signed [39:0] v);
    din_a = v; vld_a = 1'b1; tick();
  endtask

  task automatic feed_b(input logic signed [39:0] v);
    din_b = v; vld_b = 1'b1; tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", ov_a, 0);
    chk("rst_level", lvl_a, 0);
    chk("rst_data", dout_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_ovf", ovf_a, 0);

    // Gain and latency
    rdy_a = 1'b1;
    feed_a(40'sd3276800); vld_a = 1'b0;
    chk("gain_lat_n", ov_a, 0);
    tick();
    chk("gain_lat_n1", ov_a, 0);
    tick();
    chk("gain_valid", ov_a, 1);
    chk("gain_data", dout_a, 100);
    tick();
    chk("gain_popped", ov_a, 0);

    // Rounding, collected under backpressure
    rdy_a = 1'b0;
    feed_a(40'sd16384); feed_a(40'sd16383); feed_a(-40'sd16384); feed_a(-40'sd16385);
    vld_a = 1'b0; tick(); tick();
    chk("rnd_level", lvl_a, 4);
    chk("rnd_sat", sat_a, 0);
    chk("rnd_ovf", ovf_a, 0);
    rdy_a = 1'b1;
    chk("rnd_0", dout_a, 1);  tick();
    chk("rnd_1", dout_a, 0);  tick();
    chk("rnd_2", dout_a, 0);  tick();
    chk("rnd_3", dout_a, -1); tick();
    chk("rnd_empty", ov_a, 0);

    // Saturation
    rdy_a = 1'b0;
    feed_a(40'sd274877906944); feed_a(-40'sd274877906944);
    vld_a = 1'b0; tick(); tick();
    chk("sat_level", lvl_a, 2);
    chk("sat_flag", sat_a, 1);
`ifdef FIR_SAT_COUNT_EN
    chk("sat_count", cnt_a, 2);
`endif
    rdy_a = 1'b1;
    chk("sat_pos", dout_a, 65535);  tick();
    chk("sat_neg", dout_a, -65536); tick();
    chk("sat_empty", ov_a, 0);

    // Decimation by two with a gap between k=2 and k=3
    rdy_b = 1'b0;
    feed_b(40'sd32768); feed_b(40'sd65536);
    vld_b = 1'b0; tick();
    feed_b(40'sd98304); feed_b(40'sd131072); feed_b(40'sd163840); feed_b(40'sd196608);
    vld_b = 1'b0; tick(); tick();
    chk("dec_level", lvl_b, 3);
    rdy_b = 1'b1;
    chk("dec_0", dout_b, 1); tick();
    chk("dec_1", dout_b, 3); tick();
    chk("dec_2", dout_b, 5); tick();
    chk("dec_empty", ov_b, 0);

    // Backpressure and overflow
    rdy_a = 1'b0;
    for (int k = 1; k <= 5; k++) feed_a(40'(k * 32768));
    vld_a = 1'b0; tick(); tick();
    chk("bp_level", lvl_a, 4);
    chk("bp_ovf", ovf_a, 1);
    chk("bp_sat", sat_a, 0);
    tick();
    chk("bp_hold", dout_a, 1);
    rdy_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_drain", dout_a, k);
      tick();
    end
    chk("bp_empty", ov_a, 0);
    chk("bp_ovf_sticky", ovf_a, 1);

    // Reset mid-operation
    rdy_a = 1'b0;
    feed_a(40'sd229376); feed_a(40'sd262144); feed_a(40'sd294912);
    vld_a = 1'b0; tick(); tick();
    chk("mid_level", lvl_a, 3);
    rst = 1'b1; rdy_a = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid", ov_a, 0);
    chk("mid_level0", lvl_a, 0);
    chk("mid_ovf", ovf_a, 0);
    chk("mid_data", dout_a, 0);
    rdy_a = 1'b0;
    feed_a(40'sd32768); vld_a = 1'b0; tick(); tick();
    chk("post_valid", ov_a, 1);
    chk("post_data", dout_a, 1);
    chk("post_level", lvl_a, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_output_conditioner.md
Name: fir_output_conditioner

Overview:
- Sits directly downstream of the 9-tap tree-adder FIR.
- Consumes its 40-bit signed full-precision output every clock and rescales it by the Q15 coefficient gain: round, then saturate back to the 17-bit sample width.
- Optionally decimates, then buffers results in a small FIFO behind a valid/ready output handshake for the next consumer.

Parameters:
- IN_W, 40, width of the filter output word.
- OUT_W, 17, width of the conditioned sample.
- SHIFT, 15, right-shift applied after rounding (Q15 coefficient scale).
- DECIM, 1, decimation factor, 1..16; 1 = keep every sample.
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥2.

Ports:
- clock95  in  1  single clock; all state updates on rising edge.
- reset95  in  1  synchronous, active-high reset.
- filter_output95  in  IN_W  signed filter result, two's complement.
- in_valid95  in  1  filter_output95 is a new sample this cycle.
- out_data95  out  OUT_W  signed conditioned sample at FIFO head.
- out_valid95  out  1  FIFO non-empty.
- out_ready95  in  1  consumer accepts out_data95 when high with out_valid95.
- fifo_level95  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- sat_flag95  out  1  the most recent sample pushed into the FIFO was saturated.
- overflow95  out  1  sticky; a kept sample was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, clock95. Reset reset95 is synchronous and active-high.
- Reset state: while reset95 is high at a rising edge, all of the following clear:
  - out_data95=0, out_valid95=0, fifo_level95=0, sat_flag95=0, overflow95=0;
  - pipeline valids, decimation counter and FIFO pointers.
  - Reset overrides every other event in the same cycle, including a mid-burst transfer; in-flight samples are discarded.
- Stage 1 (round), registered:
  - r = (filter_output95 + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits.
  - This is round-half-toward-+inf; no intermediate wrap.
- Stage 2 (saturate), registered:
  - If r > 2^(OUT_W-1)-1, clamp to 65535 and mark saturated.
  - If r < -2^(OUT_W-1), clamp to -65536 and mark saturated.
  - Otherwise truncate to OUT_W.
- Decimation:
  - A counter 0..DECIM-1 advances on each valid stage-2 sample and wraps.
  - The sample is kept only when the counter is 0 before the advance; the first valid sample after reset is always kept.
  - Invalid cycles do not advance the counter.
- Latency: a sample sampled with in_valid95 at edge N is pushed at edge N+2. out_valid95 rises after edge N+2 when the FIFO was empty.
- Handshake:
  - Pop occurs on a rising edge where out_valid95 & out_ready95.
  - out_data95 is stable while out_valid95 is high and out_ready95 is low.
  - out_ready95 while empty has no effect.
- FIFO full, no pop: a kept sample is dropped and overflow95 sets and stays set until reset.
- FIFO full with simultaneous push and pop: both happen, no drop, level unchanged.
- Empty with simultaneous push and no pop: level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level95 is registered and never exceeds FIFO_DEPTH.
- sat_flag95 updates only on a successful push.

Optional Feature:
- Macro: FIR_SAT_COUNT_EN.
- When defined: adds output port sat_count95 (16 bits).
  - Counts saturated samples that were successfully pushed.
  - Holds at 0xFFFF; does not wrap.
  - Cleared by reset95.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Gain: DECIM=1, out_ready95=1, filter_output95=3276800 valid one cycle -> out_valid95 high after edge N+2 with out_data95=100, then low once popped.
2. Rounding: inputs 16384, 16383, -16384, -16385 -> outputs 1, 0, 0, -1 in order; sat_flag95=0 throughout.
3. Saturation: inputs 2^38 and -2^38 -> outputs 65535 then -65536, sat_flag95=1; with FIR_SAT_COUNT_EN, sat_count95=2.
4. Decimation: DECIM=2, inputs k*32768 for k=1..6 consecutive -> outputs 1, 3, 5 only; a gap in in_valid95 between k=2 and k=3 does not change the result.
5. Backpressure: DECIM=1, FIFO_DEPTH=4, out_ready95=0, push values 1..5:
   - fifo_level95=4, overflow95=1;
   - raise out_ready95 -> 1, 2, 3, 4 drained in order, value 5 never appears, overflow95 stays 1.
6. Reset mid-operation: FIFO holding 3 entries, assert reset95 one cycle with out_ready95=1 -> next cycle out_valid95=0, fifo_level95=0, overflow95=0; the next input 32768 -> output 1.
